// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
//   Round-robin arbiter that shares one 8:1 mux output channel among eight
//   requesters. A requester keeps the grant for at most MAX_HOLD consecutive
//   cycles while others are waiting. The grant, the select code and the valid
//   flag are registered. The winner's data goes through a combinational 8:1
//   mux that is driven from the registered select.
//
//   Parameters
//     DATA_W   : width of each requester's data word
//     MAX_HOLD : maximum consecutive grant cycles while others wait (1..15)
//
//   Ports
//     clk       : rising-edge clock
//     rst       : synchronous, active-high reset
//     urgent    : (only with ARB_URGENT_EN) pre-emptive grant to requester 0
//     req       : request bit per requester (bit i = requester i)
//     data_in   : requester data, slice i = data_in[i*DATA_W +: DATA_W]
//     grant     : registered one-hot grant, all zero when idle
//     sel       : registered select code of the current grantee
//     out_data  : data of the current grantee, zero when idle
//     out_valid : registered, high while a grant is active
//
//   Optional feature macro: ARB_URGENT_EN adds the urgent input.
//   The default build leaves it undefined.
module mux8_rr_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef ARB_URGENT_EN
  input  logic                  urgent,
`endif
  input  logic [7:0]            req,
  input  logic [8*DATA_W-1:0]   data_in,
  output logic [7:0]            grant,
  output logic [2:0]            sel,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic [7:0]  grant_q, grant_d;
  logic [2:0]  sel_q, sel_d;
  logic        valid_q, valid_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;

  logic [3:0]  idle_pick;
  logic [3:0]  rescan_pick;
  logic        others_req;
  logic        hold_expired;
  logic        release_now;

  // Returns {found, index} for the first set bit at start, start+1, ... (mod 8).
  // The loop runs downward, so the closest hit is assigned last and wins.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    idle_pick    = pick(req, ptr_q);
    // The release rescan starts just past the current grantee. The grantee
    // itself is reached last, so anyone else who is waiting wins first.
    rescan_pick  = pick(req, sel_q + 3'd1);
    others_req   = |(req & ~(8'd1 << sel_q));
    hold_expired = (hold_cnt_q == HOLD_LAST);
    release_now  = !req[sel_q] || (hold_expired && others_req);

    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      IDLE: begin
        if (idle_pick[3]) begin
          state_d    = BUSY;
          sel_d      = idle_pick[2:0];
          grant_d    = 8'd1 << idle_pick[2:0];
          valid_d    = 1'b1;
          hold_cnt_d = 4'd0;
        end
      end
      BUSY: begin
        if (release_now) begin
          ptr_d      = sel_q + 3'd1;
          hold_cnt_d = 4'd0;
          if (rescan_pick[3]) begin
            // Hand over at this edge, so there is no idle bubble.
            sel_d   = rescan_pick[2:0];
            grant_d = 8'd1 << rescan_pick[2:0];
          end else begin
            state_d = IDLE;
            grant_d = 8'd0;
            valid_d = 1'b0;
          end
        end else if (hold_expired) begin
          // Sole requester: it keeps the grant and starts a fresh hold window.
          hold_cnt_d = 4'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'd0;
        valid_d = 1'b0;
      end
    endcase

`ifdef ARB_URGENT_EN
    // Urgent pre-emption overrides everything. Restarting the hold count on
    // every urgent cycle keeps requester 0 from expiring while urgent is high.
    // Its eventual release sets ptr to sel+1 = 1.
    if (urgent && req[0]) begin
      state_d    = BUSY;
      sel_d      = 3'd0;
      grant_d    = 8'd1;
      valid_d    = 1'b1;
      hold_cnt_d = 4'd0;
      ptr_d      = ptr_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 8'd0;
      sel_q      <= 3'd0;
      valid_q    <= 1'b0;
      ptr_q      <= 3'd0;
      hold_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Output mux, combinational from the registered select.
  always_comb begin
    out_data = '0;
    if (valid_q) out_data = data_in[sel_q*DATA_W +: DATA_W];
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

  localparam int DW = 4;
  localparam int MH = 4;
  localparam int VW = 8 + 3 + 1 + DW;

  logic              clk;
  logic              rst;
  logic              urgent;
  logic [7:0]        req;
  logic [8*DW-1:0]   data_in;
  logic [7:0]        grant;
  logic [2:0]        sel;
  logic [DW-1:0]     out_data;
  logic              out_valid;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: who owns the channel and for how long.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_held;

  mux8_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ARB_URGENT_EN
    .urgent    (urgent),
`endif
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_pick(logic [7:0] r, int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic r_rst, input logic [7:0] r_req);
    int w;
    bit others;
    if (r_rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0;
    end else if (!m_busy) begin
      w = m_pick(r_req, m_ptr);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_held = 1;
      end
    end else begin
      others = (r_req & ~(8'd1 << m_owner)) != 8'd0;
      if (!r_req[m_owner] || (m_held >= MH && others)) begin
        m_ptr = (m_owner + 1) % 8;
        w = m_pick(r_req, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_held = 1;
        end else begin
          m_busy = 0;
        end
      end else if (m_held >= MH) begin
        m_held = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [7:0]    g;
    logic [DW-1:0] d;
    g = m_busy ? (8'd1 << m_owner) : 8'd0;
    d = m_busy ? data_in[m_owner*DW +: DW] : '0;
    return {g, 3'(m_owner), m_busy, d};
  endfunction

  // One clock: drive inputs, let the edge happen, update the model, then move
  // to the falling edge for sampling.
  task automatic drive(input logic r_rst, input logic [7:0] r_req);
    rst     = r_rst;
    req     = r_req;
    data_in = 32'($urandom);
    @(posedge clk);
    model_edge(r_rst, r_req);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'hFF);
      n_chk++;
      if ({grant, sel, out_valid, out_data} !== {VW{1'b0}}) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got %h required %h", i,
                 {grant, sel, out_valid, out_data}, {VW{1'b0}});
      end
    end
  endtask

  task automatic test_single();
    logic [VW-1:0] act;
    rst = 1'b0; req = 8'h08; data_in = 32'h0000_1000;
    @(posedge clk); model_edge(1'b0, 8'h08); @(negedge clk);
    act = {grant, sel, out_valid, out_data};
    n_chk++;
    if (act !== {8'h08, 3'd3, 1'b1, 4'h1}) begin
      n_fail++;
      $display("FAIL single_grant: got %h required %h", act, {8'h08, 3'd3, 1'b1, 4'h1});
    end
    drive(1'b0, 8'h00);
    n_chk++;
    if ({grant, out_valid} !== 9'd0) begin
      n_fail++;
      $display("FAIL single_release: got grant=%h valid=%b required 00/0", grant, out_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_sel;
    drive(1'b1, 8'h00);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 8'hFF);
      exp_sel = (i / MH) % 8;
      n_chk++;
      if (sel !== 3'(exp_sel) || out_valid !== 1'b1 || {grant, sel, out_valid, out_data} !== exp_vec()) begin
        n_fail++;
        $display("FAIL round_robin cyc %0d: got sel=%0d valid=%b vec=%h required sel=%0d vec=%h",
                 i, sel, out_valid, {grant, sel, out_valid, out_data}, exp_sel, exp_vec());
      end
    end
  endtask

  task automatic test_sole();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 8'h20);
      n_chk++;
      if (grant !== 8'h20 || out_valid !== 1'b1 || {grant, sel, out_valid, out_data} !== exp_vec()) begin
        n_fail++;
        $display("FAIL sole cyc %0d: got grant=%h valid=%b required grant=20 valid=1", i, grant, out_valid);
      end
    end
  endtask

  task automatic test_early_release();
    drive(1'b1, 8'h00);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h05);
      n_chk++;
      if (grant !== 8'h01 || sel !== 3'd0) begin
        n_fail++;
        $display("FAIL early_hold cyc %0d: got grant=%h sel=%0d required 01/0", i, grant, sel);
      end
    end
    drive(1'b0, 8'h04);
    n_chk++;
    if (grant !== 8'h04 || sel !== 3'd2 || out_valid !== 1'b1 || {grant, sel, out_valid, out_data} !== exp_vec()) begin
      n_fail++;
      $display("FAIL early_release: got grant=%h sel=%0d valid=%b required 04/2/1", grant, sel, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    drive(1'b1, 8'h00);
    guard = 0;
    do begin
      drive(1'b0, 8'hFF);
      guard++;
    end while (!(m_busy && m_owner == 5) && guard < 100);
    n_chk++;
    if (sel !== 3'd5 || guard >= 100) begin
      n_fail++;
      $display("FAIL reset_mid_reach: got sel=%0d after %0d cycles required 5", sel, guard);
    end
    drive(1'b1, 8'hFF);
    n_chk++;
    if (grant !== 8'h00 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_drop: got grant=%h valid=%b required 00/0", grant, out_valid);
    end
    drive(1'b0, 8'hFF);
    n_chk++;
    if (grant !== 8'h01 || sel !== 3'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_regrant: got grant=%h sel=%0d required 01/0", grant, sel);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic       rr;
    r = 8'h00;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: r = 8'($urandom);
        1: r = 8'($urandom) & 8'($urandom);
        2: r = r ^ (8'd1 << $urandom_range(0, 7));
        default: r = r;
      endcase
      rr = ($urandom_range(0, 99) == 0);
      drive(rr, r);
      n_chk++;
      if ({grant, sel, out_valid, out_data} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d req=%h: got %h required %h", i, r,
                 {grant, sel, out_valid, out_data}, exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; urgent = 1'b0; req = 8'h00; data_in = '0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_sole();
    test_early_release();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
